hdc_am_classifier: RTL and testbench

- Associative-memory search stage downstream of the window encoder. It takes one query window hypervector (window_hv) and finds the stored class prototype HV at the smallest Hamming distance.
- Outputs the winning class index (e.g. 0 = interictal, 1 = ictal) and its distance.
- Distance is computed serially, CHUNK bits per cycle, so area is bounded for D = 10000.

---
 rtl/hdc_pkg.sv | 23 ++
 rtl/hdc_am_classifier_if.sv | 36 +++
 rtl/hv_chunk_popcount.sv | 24 ++
 rtl/hdc_am_classifier.sv | 153 +++++++++++++++
 tb/tb_hdc_am_classifier.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared hyperdimensional classifier types and constants
package hdc_pkg;

    localparam int HDC_DIMENSIONS  = 10000;
    localparam int HDC_NUM_CLASSES = 2;

    typedef logic [HDC_DIMENSIONS-1:0] hv_t;

    localparam int CLS_INTERICTAL = 0;
    localparam int CLS_ICTAL      = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } am_state_e;

    // Width needed to hold any Hamming distance 0..dims inclusive.
    function automatic int dist_width(input int dims);
        return $clog2(dims + 1);
    endfunction

endpackage

// File: rtl/hdc_am_classifier_if.sv
// rtl/hdc_am_classifier_if.sv - prototype load, query and result handshakes
interface hdc_am_classifier_if
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS  = HDC_DIMENSIONS,
    parameter int NUM_CLASSES = HDC_NUM_CLASSES
) ();

    localparam int AW = $clog2(NUM_CLASSES);
    localparam int DW = dist_width(DIMENSIONS);

    logic                  proto_we;
    logic [AW-1:0]         proto_addr;
    logic [DIMENSIONS-1:0] proto_hv;
    logic                  proto_ready;

    logic                  query_valid;
    logic                  query_ready;
    logic [DIMENSIONS-1:0] query_hv;

    logic                  result_valid;
    logic                  result_ready;
    logic [AW-1:0]         class_out;
    logic [DW-1:0]         dist_out;

    modport master (
        output proto_we, proto_addr, proto_hv, query_valid, query_hv, result_ready,
        input  proto_ready, query_ready, result_valid, class_out, dist_out
    );

    modport slave (
        input  proto_we, proto_addr, proto_hv, query_valid, query_hv, result_ready,
        output proto_ready, query_ready, result_valid, class_out, dist_out
    );

endinterface

// File: rtl/hv_chunk_popcount.sv
// rtl/hv_chunk_popcount.sv - XOR and popcount of one hypervector chunk
module hv_chunk_popcount #(
    parameter int CHUNK = 500
) (
    input  logic [CHUNK-1:0]             a_chunk,
    input  logic [CHUNK-1:0]             b_chunk,
    output logic [$clog2(CHUNK+1)-1:0]   count
);

    localparam int PW = $clog2(CHUNK + 1);

    logic [CHUNK-1:0] diff;

    assign diff = a_chunk ^ b_chunk;

    // Written as a flat sum; synthesis rebalances it into an adder tree.
    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + PW'(diff[i]);
        end
    end

endmodule

// File: rtl/hdc_am_classifier.sv
// rtl/hdc_am_classifier.sv - serial Hamming-distance associative-memory search
module hdc_am_classifier
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS  = HDC_DIMENSIONS,
    parameter int NUM_CLASSES = HDC_NUM_CLASSES,
    parameter int CHUNK       = 500
) (
    input logic                clk,
    input logic                nrst,
    hdc_am_classifier_if.slave bus
);

    localparam int NCH = DIMENSIONS / CHUNK;
    localparam int DW  = dist_width(DIMENSIONS);
    localparam int AW  = $clog2(NUM_CLASSES);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(CHUNK + 1);

    am_state_e             state_q, state_d;
    logic [DIMENSIONS-1:0] query_q, query_d;
    logic [CW-1:0]         chunk_idx_q, chunk_idx_d;
    logic [AW-1:0]         class_idx_q, class_idx_d;
    logic [DW-1:0]         acc_q, acc_d;
    logic [DW-1:0]         best_dist_q, best_dist_d;
    logic [AW-1:0]         best_class_q, best_class_d;
    logic [AW-1:0]         class_out_q, class_out_d;
    logic [DW-1:0]         dist_out_q, dist_out_d;

    // Prototype storage is deliberately unreset; slots are undefined until loaded.
    logic [DIMENSIONS-1:0] proto_mem [NUM_CLASSES];

    logic [CHUNK-1:0] q_chunk;
    logic [CHUNK-1:0] p_chunk;
    logic [PW-1:0]    pc;
    logic [DW-1:0]    class_total;
    logic             take_new;
    logic             last_chunk;
    logic             last_class;
    logic             idle;
    logic             proto_wr;

    assign idle     = (state_q == ST_IDLE);
    assign proto_wr = idle && bus.proto_we && (32'(bus.proto_addr) < NUM_CLASSES);

    assign q_chunk = query_q[int'(chunk_idx_q)*CHUNK +: CHUNK];
    assign p_chunk = proto_mem[class_idx_q][int'(chunk_idx_q)*CHUNK +: CHUNK];

    hv_chunk_popcount #(
        .CHUNK (CHUNK)
    ) u_popcount (
        .a_chunk (q_chunk),
        .b_chunk (p_chunk),
        .count   (pc)
    );

    assign class_total = acc_q + DW'(pc);
    // Strict compare: on a tie the earlier (lower-index) class keeps the win.
    assign take_new    = (class_total < best_dist_q);
    assign last_chunk  = (int'(chunk_idx_q) == NCH - 1);
    assign last_class  = (int'(class_idx_q) == NUM_CLASSES - 1);

    always_ff @(posedge clk) begin
        if (proto_wr) begin
            proto_mem[bus.proto_addr] <= bus.proto_hv;
        end
    end

    always_comb begin
        state_d      = state_q;
        query_d      = query_q;
        chunk_idx_d  = chunk_idx_q;
        class_idx_d  = class_idx_q;
        acc_d        = acc_q;
        best_dist_d  = best_dist_q;
        best_class_d = best_class_q;
        class_out_d  = class_out_q;
        dist_out_d   = dist_out_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.query_valid) begin
                    query_d      = bus.query_hv;
                    chunk_idx_d  = '0;
                    class_idx_d  = '0;
                    acc_d        = '0;
                    best_dist_d  = '1;
                    best_class_d = '0;
                    state_d      = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (last_chunk) begin
                    acc_d       = '0;
                    chunk_idx_d = '0;
                    class_idx_d = class_idx_q + AW'(1);
                    if (take_new) begin
                        best_dist_d  = class_total;
                        best_class_d = class_idx_q;
                    end
                    if (last_class) begin
                        // Capture the final winner directly so DONE presents it at once.
                        class_out_d = take_new ? class_idx_q : best_class_q;
                        dist_out_d  = take_new ? class_total : best_dist_q;
                        state_d     = ST_DONE;
                    end
                end else begin
                    acc_d       = class_total;
                    chunk_idx_d = chunk_idx_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            query_q      <= '0;
            chunk_idx_q  <= '0;
            class_idx_q  <= '0;
            acc_q        <= '0;
            best_dist_q  <= '0;
            best_class_q <= '0;
            class_out_q  <= '0;
            dist_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            query_q      <= query_d;
            chunk_idx_q  <= chunk_idx_d;
            class_idx_q  <= class_idx_d;
            acc_q        <= acc_d;
            best_dist_q  <= best_dist_d;
            best_class_q <= best_class_d;
            class_out_q  <= class_out_d;
            dist_out_q   <= dist_out_d;
        end
    end

    assign bus.proto_ready  = idle;
    assign bus.query_ready  = idle;
    assign bus.result_valid = (state_q == ST_DONE);
    assign bus.class_out    = class_out_q;
    assign bus.dist_out     = dist_out_q;

endmodule

// File: tb/tb_hdc_am_classifier.sv
// tb/tb_hdc_am_classifier.sv - directed self-checking bench for hdc_am_classifier
module tb_hdc_am_classifier;

    localparam int D  = 10000;
    localparam int NC = 2;
    localparam int CK = 500;

    typedef logic [D-1:0] hv_l;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    hdc_am_classifier_if #(.DIMENSIONS(D), .NUM_CLASSES(NC)) bus ();

    hdc_am_classifier #(
        .DIMENSIONS  (D),
        .NUM_CLASSES (NC),
        .CHUNK       (CK)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic hv_l ones_hv(input int n);
        hv_l v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic write_proto(input int addr, input hv_l hv);
        @(negedge clk);
        bus.proto_we   = 1'b1;
        bus.proto_addr = addr[0];
        bus.proto_hv   = hv;
        @(posedge clk);
        #1;
        bus.proto_we   = 1'b0;
    endtask

    task automatic start_query(input hv_l hv);
        @(negedge clk);
        bus.query_valid = 1'b1;
        bus.query_hv    = hv;
        @(posedge clk);
        #1;
        bus.query_valid = 1'b0;
    endtask

    // Returns the cycle index (accept cycle = 0) at which result_valid is seen, or -1.
    task automatic wait_result(output int lat);
        int n;
        n = 0;
        while (bus.result_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = (bus.result_valid === 1'b1) ? n + 1 : -1;
        check_eq("result_timeout", int'(lat >= 0), 1);
    endtask

    task automatic accept_result();
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        check_eq("accept_valid_low", int'(bus.result_valid), 0);
        check_eq("accept_query_ready", int'(bus.query_ready), 1);
    endtask

    task automatic run_case(input string tag, input hv_l hv, input int exp_cls, input int exp_dist);
        int lat;
        start_query(hv);
        wait_result(lat);
        check_eq({tag, "_class"}, int'(bus.class_out), exp_cls);
        check_eq({tag, "_dist"}, int'(bus.dist_out), exp_dist);
        accept_result();
    endtask

    initial begin
        int lat;
        int seen;
        checks = 0;
        errors = 0;
        nrst             = 1'b0;
        bus.proto_we     = 1'b0;
        bus.proto_addr   = '0;
        bus.proto_hv     = '0;
        bus.query_valid  = 1'b0;
        bus.query_hv     = '0;
        bus.result_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_result_valid", int'(bus.result_valid), 0);
        check_eq("rst_class_out", int'(bus.class_out), 0);
        check_eq("rst_dist_out", int'(bus.dist_out), 0);
        check_eq("rst_query_ready", int'(bus.query_ready), 1);
        check_eq("rst_proto_ready", int'(bus.proto_ready), 1);
        @(negedge clk);
        nrst = 1'b1;

        write_proto(0, '0);
        write_proto(1, '1);

        // 3000 ones: latency and nearest-to-zeros result.
        start_query(ones_hv(3000));
        wait_result(lat);
        check_eq("q3000_latency", lat, 41);
        check_eq("q3000_class", int'(bus.class_out), 0);
        check_eq("q3000_dist", int'(bus.dist_out), 3000);
        accept_result();

        run_case("q7000", ones_hv(7000), 1, 3000);
        run_case("q5000_tie", ones_hv(5000), 0, 5000);

        // Back-pressure: result held, ready outputs low, stray query ignored.
        start_query(ones_hv(3000));
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.query_valid = (i == 3);
            bus.query_hv    = ones_hv(9000);
            check_eq("hold_valid", int'(bus.result_valid), 1);
            check_eq("hold_class", int'(bus.class_out), 0);
            check_eq("hold_dist", int'(bus.dist_out), 3000);
            check_eq("hold_query_ready", int'(bus.query_ready), 0);
        end
        bus.query_valid = 1'b0;
        accept_result();

        // Prototype write during SCAN must be dropped.
        start_query(ones_hv(7000));
        repeat (5) @(posedge clk);
        #1;
        check_eq("scan_proto_ready", int'(bus.proto_ready), 0);
        bus.proto_we   = 1'b1;
        bus.proto_addr = 1'b1;
        bus.proto_hv   = '0;
        @(posedge clk);
        #1;
        bus.proto_we   = 1'b0;
        wait_result(lat);
        check_eq("scanwr_class", int'(bus.class_out), 1);
        check_eq("scanwr_dist", int'(bus.dist_out), 3000);
        accept_result();
        run_case("requery", ones_hv(7000), 1, 3000);

        // Reset in SCAN cycle 15 aborts with no result.
        start_query(ones_hv(3000));
        repeat (14) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_eq("abort_query_ready", int'(bus.query_ready), 1);
        check_eq("abort_result_valid", int'(bus.result_valid), 0);
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid === 1'b1) seen++;
        end
        check_eq("abort_no_result", seen, 0);
        run_case("post_rst", '1, 1, 0);

        // Same-cycle write and query: the new slot-0 prototype is used.
        @(negedge clk);
        bus.proto_we    = 1'b1;
        bus.proto_addr  = 1'b0;
        bus.proto_hv    = '1;
        bus.query_valid = 1'b1;
        bus.query_hv    = '1;
        @(posedge clk);
        #1;
        bus.proto_we    = 1'b0;
        bus.query_valid = 1'b0;
        wait_result(lat);
        check_eq("samecyc_class", int'(bus.class_out), 0);
        check_eq("samecyc_dist", int'(bus.dist_out), 0);
        accept_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
